// File: rtl/cart_pkg.sv
// Shared definitions for the cartridge word loader: default widths, FSM states and the
// word-width helper used by the colour decoder, loader and CPU fetch side.
package cart_pkg;

  localparam int unsigned CART_SYM_W         = 2;
  localparam int unsigned CART_SYMS_PER_WORD = 6;
  localparam int unsigned CART_ADDR_W        = 8;
  localparam int unsigned CART_WORDS         = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } cart_state_e;

  function automatic int unsigned word_w(input int unsigned sym_w,
                                         input int unsigned syms_per_word);
    return sym_w * syms_per_word;
  endfunction

endpackage

// File: rtl/prog_ram.sv
// Simple dual-port program RAM: synchronous write, registered read-first read port.
module prog_ram #(
  parameter int unsigned WIDTH  = 12,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];

  // Both updates are non-blocking, so a same-address read sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/cart_word_loader.sv
// Packs colour symbols from the cartridge reader into program words and fills the program RAM,
// with frame resync, completion/overflow status and a running XOR checksum.
module cart_word_loader
  import cart_pkg::*;
#(
  parameter int unsigned SYM_W          = CART_SYM_W,
  parameter int unsigned SYMS_PER_WORD  = CART_SYMS_PER_WORD,
  parameter int unsigned ADDR_W         = CART_ADDR_W,
  parameter int unsigned WORDS_EXPECTED = CART_WORDS,
  parameter bit          MSB_FIRST      = 1'b1
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      sym_valid,
  input  logic [SYM_W-1:0]                          sym_data,
  input  logic                                      frame_start,
  input  logic [ADDR_W-1:0]                         rd_addr,
  output logic [word_w(SYM_W, SYMS_PER_WORD)-1:0]   rd_data,
  output logic                                      loading,
  output logic                                      load_done,
  output logic                                      overflow,
  output logic [ADDR_W:0]                           words_written,
  output logic [word_w(SYM_W, SYMS_PER_WORD)-1:0]   checksum
);

  localparam int unsigned WORD_W = word_w(SYM_W, SYMS_PER_WORD);
  localparam int unsigned CNT_W  = (SYMS_PER_WORD > 1) ? $clog2(SYMS_PER_WORD) : 1;
  localparam logic [CNT_W-1:0] LAST_SYM   = CNT_W'(SYMS_PER_WORD - 1);
  localparam logic [ADDR_W:0]  WORDS_FULL = (ADDR_W + 1)'(WORDS_EXPECTED);

  cart_state_e       state_q, state_d;
  logic [CNT_W-1:0]  sym_cnt_q, sym_cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] shifted;
  logic [ADDR_W:0]   words_q, words_d;
  logic [WORD_W-1:0] csum_q, csum_d;
  logic              overflow_q, overflow_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;
  logic              accept;

  // Shifts are used instead of slices so SYMS_PER_WORD = 1 stays legal.
  always_comb begin
    if (MSB_FIRST) begin
      shifted = (shift_q << SYM_W) | WORD_W'(sym_data);
    end else begin
      shifted = (shift_q >> SYM_W) | (WORD_W'(sym_data) << (WORD_W - SYM_W));
    end
  end

  always_comb begin
    state_d    = state_q;
    sym_cnt_d  = sym_cnt_q;
    shift_d    = shift_q;
    words_d    = words_q;
    csum_d     = csum_q;
    overflow_d = overflow_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    // frame_start rebases the frame first; a coincident symbol then lands as symbol 0.
    if (frame_start) begin
      state_d    = LOAD;
      sym_cnt_d  = '0;
      words_d    = '0;
      csum_d     = '0;
      overflow_d = 1'b0;
    end else if (state_q == DONE && sym_valid) begin
      overflow_d = 1'b1;
    end

    accept = sym_valid && (frame_start || state_q == LOAD);

    if (accept) begin
      shift_d = shifted;
      if (sym_cnt_d == LAST_SYM) begin
        wr_en_d   = 1'b1;
        wr_addr_d = words_d[ADDR_W-1:0];
        wr_data_d = shifted;
        csum_d    = csum_d ^ shifted;
        words_d   = words_d + 1'b1;
        sym_cnt_d = '0;
        if (words_d == WORDS_FULL) begin
          state_d = DONE;
        end
      end else begin
        sym_cnt_d = sym_cnt_d + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sym_cnt_q  <= '0;
      shift_q    <= '0;
      words_q    <= '0;
      csum_q     <= '0;
      overflow_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      sym_cnt_q  <= sym_cnt_d;
      shift_q    <= shift_d;
      words_q    <= words_d;
      csum_q     <= csum_d;
      overflow_q <= overflow_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  prog_ram #(
    .WIDTH  (WORD_W),
    .ADDR_W (ADDR_W)
  ) u_prog_ram (
    .clk     (clk),
    .wr_en   (wr_en_q),
    .wr_addr (wr_addr_q),
    .wr_data (wr_data_q),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign loading       = (state_q == LOAD);
  assign load_done     = (state_q == DONE);
  assign overflow      = overflow_q;
  assign words_written = words_q;
  assign checksum      = csum_q;

endmodule
